// File: rtl/tlb_maintenance_unit_pkg.sv
// Shared TLB definitions: geometry, field widths, maintenance command encodings and FSM states.
package tlb_maintenance_unit_pkg;

  localparam int unsigned TLB_ENTRY_COUNT = 32;
  localparam int unsigned INDEX_WIDTH     = $clog2(TLB_ENTRY_COUNT);
  localparam int unsigned KEY_WIDTH       = 20;
  // {frame[19:0], write, valid}
  localparam int unsigned FRAME_WIDTH     = KEY_WIDTH + 2;

  typedef enum logic [1:0] {
    CmdSearch       = 2'b00,
    CmdReadIndexed  = 2'b01,
    CmdWriteIndexed = 2'b10,
    CmdWriteRandom  = 2'b11
  } tlbCommand_e;

  typedef enum logic [1:0] {
    StIdle,
    StExecute,
    StDone
  } tlbState_e;

  function automatic logic isWriteCommand(input tlbCommand_e cmd);
    return (cmd == CmdWriteIndexed) || (cmd == CmdWriteRandom);
  endfunction

endpackage

// File: rtl/tlb_maintenance_unit_if.sv
// Command/result handshake plus key and frame memory ports of the TLB maintenance unit.
interface tlb_maintenance_unit_if;
  import tlb_maintenance_unit_pkg::*;

  logic                   commandValid;
  logic                   commandReady;
  logic [1:0]             command;
  logic [INDEX_WIDTH-1:0] commandIndex;
  logic [KEY_WIDTH-1:0]   commandKey;
  logic [FRAME_WIDTH-1:0] commandFrame;

  logic                   done;
  logic                   resultFound;
  logic [INDEX_WIDTH-1:0] resultIndex;
  logic [KEY_WIDTH-1:0]   resultKey;
  logic [FRAME_WIDTH-1:0] resultFrame;
  logic [INDEX_WIDTH-1:0] randomIndex;

  logic [INDEX_WIDTH-1:0] keyAccessIndex;
  logic [KEY_WIDTH-1:0]   keyWriteValue;
  logic                   keyWriteEnable;
  logic [KEY_WIDTH-1:0]   keyReadValue;
  logic [KEY_WIDTH-1:0]   keySearchKey;
  logic                   keyFound;
  logic [INDEX_WIDTH-1:0] keyFoundIndex;

  logic [INDEX_WIDTH-1:0] frameAccessIndex;
  logic [FRAME_WIDTH-1:0] frameWriteValue;
  logic                   frameWriteEnable;
  logic [FRAME_WIDTH-1:0] frameReadValue;

  // Requester and memories side
  modport master (
    output commandValid, command, commandIndex, commandKey, commandFrame,
    output keyReadValue, keyFound, keyFoundIndex, frameReadValue,
    input  commandReady, done, resultFound, resultIndex, resultKey, resultFrame, randomIndex,
    input  keyAccessIndex, keyWriteValue, keyWriteEnable, keySearchKey,
    input  frameAccessIndex, frameWriteValue, frameWriteEnable
  );

  // Maintenance unit side
  modport slave (
    input  commandValid, command, commandIndex, commandKey, commandFrame,
    input  keyReadValue, keyFound, keyFoundIndex, frameReadValue,
    output commandReady, done, resultFound, resultIndex, resultKey, resultFrame, randomIndex,
    output keyAccessIndex, keyWriteValue, keyWriteEnable, keySearchKey,
    output frameAccessIndex, frameWriteValue, frameWriteEnable
  );

endinterface

// File: rtl/TlbRandomCounter.sv
// Free-running down counter choosing the TBWR replacement slot; skips the fixed low entries.
module TlbRandomCounter
  import tlb_maintenance_unit_pkg::*;
#(
  parameter int unsigned FIXED_ENTRIES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [INDEX_WIDTH-1:0] value
);

  localparam logic [INDEX_WIDTH-1:0] LastIndex  = INDEX_WIDTH'(TLB_ENTRY_COUNT - 1);
  localparam logic [INDEX_WIDTH-1:0] FloorIndex = INDEX_WIDTH'(FIXED_ENTRIES);

  logic [INDEX_WIDTH-1:0] valueQ;
  logic [INDEX_WIDTH-1:0] valueD;

  always_comb begin
    valueD = valueQ - INDEX_WIDTH'(1);
    if (valueQ <= FloorIndex) begin
      valueD = LastIndex;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valueQ <= LastIndex;
    end else begin
      valueQ <= valueD;
    end
  end

  assign value = valueQ;

endmodule

// File: rtl/tlb_maintenance_unit.sv
// TLB maintenance sequencer: search, indexed read, indexed and random write over external
// key/frame memories. Three-cycle IDLE/EXECUTE/DONE cycle per command.
module tlb_maintenance_unit
  import tlb_maintenance_unit_pkg::*;
#(
  parameter int unsigned FIXED_ENTRIES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  tlb_maintenance_unit_if.slave  bus
);

  tlbState_e              stateQ, stateD;
  logic                   accept;
  tlbCommand_e            incoming;
  tlbCommand_e            commandQ;
  logic [INDEX_WIDTH-1:0] indexQ;
  logic [KEY_WIDTH-1:0]   keyQ;
  logic [FRAME_WIDTH-1:0] frameQ;

  logic                   resultFoundQ;
  logic [INDEX_WIDTH-1:0] resultIndexQ;
  logic [KEY_WIDTH-1:0]   resultKeyQ;
  logic [FRAME_WIDTH-1:0] resultFrameQ;

  logic [INDEX_WIDTH-1:0] randomIndex;
  logic                   writeActive;

  TlbRandomCounter #(
    .FIXED_ENTRIES(FIXED_ENTRIES)
  ) randomCounter (
    .clock(clock),
    .reset(reset),
    .value(randomIndex)
  );

  assign incoming = tlbCommand_e'(bus.command);

  always_comb begin
    stateD = stateQ;
    accept = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (bus.commandValid) begin
          accept = 1'b1;
          stateD = StExecute;
        end
      end
      StExecute: stateD = StDone;
      StDone:    stateD = StIdle;
      default:   stateD = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // TBWR captures the replacement slot visible in the accept cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      commandQ <= CmdSearch;
      indexQ   <= '0;
      keyQ     <= '0;
      frameQ   <= '0;
    end else if (accept) begin
      commandQ <= incoming;
      indexQ   <= (incoming == CmdWriteRandom) ? randomIndex : bus.commandIndex;
      keyQ     <= bus.commandKey;
      frameQ   <= bus.commandFrame;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resultFoundQ <= 1'b0;
      resultIndexQ <= '0;
      resultKeyQ   <= '0;
      resultFrameQ <= '0;
    end else if (stateQ == StExecute) begin
      case (commandQ)
        CmdSearch: begin
          resultFoundQ <= bus.keyFound;
          resultIndexQ <= bus.keyFound ? bus.keyFoundIndex : '0;
        end
        CmdReadIndexed: begin
          resultKeyQ   <= bus.keyReadValue;
          resultFrameQ <= bus.frameReadValue;
        end
        default: ;
      endcase
    end
  end

  // Reset is synchronous, so it must also veto the write of the cycle it is asserted in.
  assign writeActive = (stateQ == StExecute) && isWriteCommand(commandQ) && !reset;

  assign bus.commandReady     = (stateQ == StIdle);
  assign bus.done             = (stateQ == StDone);
  assign bus.resultFound      = resultFoundQ;
  assign bus.resultIndex      = resultIndexQ;
  assign bus.resultKey        = resultKeyQ;
  assign bus.resultFrame      = resultFrameQ;
  assign bus.randomIndex      = randomIndex;

  assign bus.keyAccessIndex   = indexQ;
  assign bus.keyWriteValue    = keyQ;
  assign bus.keyWriteEnable   = writeActive;
  assign bus.keySearchKey     = keyQ;
  assign bus.frameAccessIndex = indexQ;
  assign bus.frameWriteValue  = frameQ;
  assign bus.frameWriteEnable = writeActive;

endmodule

// File: tb/tb_tlb_maintenance_unit.sv
// Randomized bench for tlb_maintenance_unit with behavioural TLB memories and a shadow model.
module tb_tlb_maintenance_unit;
  import tlb_maintenance_unit_pkg::*;

  localparam int unsigned FixedEntries = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tlb_maintenance_unit_if bus();

  tlb_maintenance_unit #(
    .FIXED_ENTRIES(FixedEntries)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Behavioural TLB memories: async read, sync write, lowest-index search.
  logic [19:0] keyMem   [32];
  logic [21:0] frameMem [32];
  logic        memLoaded = 1'b0;

  always @(posedge clock) begin
    if (!memLoaded) begin
      for (int i = 0; i < 32; i++) begin
        keyMem[i]   <= 20'hF0000 | 20'(i);
        frameMem[i] <= 22'(i * 3 + 1);
      end
      memLoaded <= 1'b1;
    end else begin
      if (bus.keyWriteEnable)   keyMem[bus.keyAccessIndex]     <= bus.keyWriteValue;
      if (bus.frameWriteEnable) frameMem[bus.frameAccessIndex] <= bus.frameWriteValue;
    end
  end

  assign bus.keyReadValue   = keyMem[bus.keyAccessIndex];
  assign bus.frameReadValue = frameMem[bus.frameAccessIndex];

  always_comb begin
    bus.keyFound      = 1'b0;
    bus.keyFoundIndex = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (keyMem[i] == bus.keySearchKey) begin
        bus.keyFound      = 1'b1;
        bus.keyFoundIndex = 5'(i);
      end
    end
  end

  // Reference model state
  int unsigned cyclesSinceReset = 0;
  always @(posedge clock) begin
    if (reset) cyclesSinceReset <= 0;
    else       cyclesSinceReset <= cyclesSinceReset + 1;
  end

  logic [19:0] refKey   [32];
  logic [21:0] refFrame [32];
  logic        expFound;
  logic [4:0]  expIndex;
  logic [19:0] expKey;
  logic [21:0] expFrame;

  int errorCount = 0;
  int checkCount = 0;

  function automatic logic [4:0] expRandom(input int unsigned n);
    return 5'(31 - (n % (32 - FixedEntries)));
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearExpectedResults();
    expFound = 1'b0;
    expIndex = 5'd0;
    expKey   = 20'd0;
    expFrame = 22'd0;
  endtask

  task automatic issue(input logic [1:0] cmd, input logic [4:0] idx, input logic [19:0] key,
                       input logic [21:0] frame);
    int         waited;
    logic [4:0] target;
    logic       isWrite;
    waited = 0;
    @(negedge clock);
    while (!bus.commandReady && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    checkValue("ready", 32'(bus.commandReady), 32'd1);
    checkValue("randomIndex", 32'(bus.randomIndex), 32'(expRandom(cyclesSinceReset)));
    target  = (cmd == CmdWriteRandom) ? expRandom(cyclesSinceReset) : idx;
    isWrite = (cmd == CmdWriteIndexed) || (cmd == CmdWriteRandom);
    bus.command      = cmd;
    bus.commandIndex = idx;
    bus.commandKey   = key;
    bus.commandFrame = frame;
    bus.commandValid = 1'b1;
    @(posedge clock);
    #1;
    // Keep valid high with different fields while busy; none of it may be taken.
    bus.command      = CmdWriteIndexed;
    bus.commandIndex = idx ^ 5'h1F;
    bus.commandKey   = ~key;
    bus.commandFrame = ~frame;
    @(negedge clock);
    checkValue("doneInExecute", 32'(bus.done), 32'd0);
    checkValue("keyWriteEnable", 32'(bus.keyWriteEnable), 32'(isWrite));
    checkValue("frameWriteEnable", 32'(bus.frameWriteEnable), 32'(isWrite));
    @(negedge clock);
    bus.commandValid = 1'b0;
    checkValue("done", 32'(bus.done), 32'd1);
    case (cmd)
      CmdSearch: begin
        expFound = 1'b0;
        expIndex = 5'd0;
        for (int i = 0; i < 32; i++) begin
          if (refKey[i] == key) begin
            expFound = 1'b1;
            expIndex = 5'(i);
            break;
          end
        end
      end
      CmdReadIndexed: begin
        expKey   = refKey[idx];
        expFrame = refFrame[idx];
      end
      default: begin
        refKey[target]   = key;
        refFrame[target] = frame;
      end
    endcase
    checkValue("resultFound", 32'(bus.resultFound), 32'(expFound));
    checkValue("resultIndex", 32'(bus.resultIndex), 32'(expIndex));
    checkValue("resultKey", 32'(bus.resultKey), 32'(expKey));
    checkValue("resultFrame", 32'(bus.resultFrame), 32'(expFrame));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          seqExp;
    int          waited;
    logic [1:0]  cmd;
    logic [4:0]  idx;
    logic [19:0] key;
    logic [21:0] frame;

    for (int i = 0; i < 32; i++) begin
      refKey[i]   = 20'hF0000 | 20'(i);
      refFrame[i] = 22'(i * 3 + 1);
    end
    clearExpectedResults();
    bus.commandValid = 1'b0;
    bus.command      = 2'b00;
    bus.commandIndex = 5'd0;
    bus.commandKey   = 20'd0;
    bus.commandFrame = 22'd0;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state and replacement counter sequence
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (c == 0) begin
        checkValue("resetReady", 32'(bus.commandReady), 32'd1);
        checkValue("resetDone", 32'(bus.done), 32'd0);
        checkValue("resetFound", 32'(bus.resultFound), 32'd0);
        checkValue("resetIndex", 32'(bus.resultIndex), 32'd0);
        checkValue("resetKey", 32'(bus.resultKey), 32'd0);
        checkValue("resetFrame", 32'(bus.resultFrame), 32'd0);
      end
      seqExp = 31 - c;
      if (seqExp < 4) seqExp += 28;
      checkValue("randomSeq", 32'(bus.randomIndex), 32'(seqExp));
      checkValue("randomFloor", 32'(bus.randomIndex >= 5'd4), 32'd1);
    end

    issue(CmdWriteIndexed, 5'd7, 20'h12345, 22'h2ABCD3);
    issue(CmdSearch, 5'd0, 20'h12345, 22'd0);
    checkValue("hitFound", 32'(bus.resultFound), 32'd1);
    checkValue("hitIndex", 32'(bus.resultIndex), 32'd7);

    issue(CmdSearch, 5'd0, 20'hFFFFF, 22'd0);
    checkValue("missFound", 32'(bus.resultFound), 32'd0);
    checkValue("missIndex", 32'(bus.resultIndex), 32'd0);

    // Line the TBWR accept up with randomIndex == 20
    @(negedge clock);
    waited = 0;
    while (expRandom(cyclesSinceReset) != 5'd21 && waited < 64) begin
      @(negedge clock);
      waited++;
    end
    issue(CmdWriteRandom, 5'd0, 20'h00042, 22'h15A5A5);
    issue(CmdReadIndexed, 5'd20, 20'd0, 22'd0);
    checkValue("tbwrKey", 32'(bus.resultKey), 32'h00042);
    checkValue("tbwrFrame", 32'(bus.resultFrame), 32'h15A5A5);

    issue(CmdWriteIndexed, 5'd9, 20'h00100, 22'h000901);
    issue(CmdWriteIndexed, 5'd3, 20'h00100, 22'h000301);
    issue(CmdSearch, 5'd0, 20'h00100, 22'd0);
    checkValue("dupLowest", 32'(bus.resultIndex), 32'd3);

    // Reset during EXECUTE of a TBWI to index 5
    @(negedge clock);
    checkValue("rstPreReady", 32'(bus.commandReady), 32'd1);
    bus.command      = CmdWriteIndexed;
    bus.commandIndex = 5'd5;
    bus.commandKey   = 20'hAAAAA;
    bus.commandFrame = 22'h3FFFFF;
    bus.commandValid = 1'b1;
    @(posedge clock);
    #1;
    bus.commandValid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checkValue("rstKeyWe", 32'(bus.keyWriteEnable), 32'd0);
    checkValue("rstFrameWe", 32'(bus.frameWriteEnable), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkValue("rstPostReady", 32'(bus.commandReady), 32'd1);
    checkValue("rstPostDone", 32'(bus.done), 32'd0);
    checkValue("rstPostRandom", 32'(bus.randomIndex), 32'd31);
    clearExpectedResults();
    issue(CmdReadIndexed, 5'd5, 20'd0, 22'd0);

    // Randomized traffic over a small key pool so searches hit and duplicates occur
    for (int n = 0; n < 40; n++) begin
      cmd   = 2'($urandom_range(0, 3));
      idx   = 5'($urandom_range(0, 31));
      key   = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h00100 + 20'($urandom_range(0, 7));
      frame = 22'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      issue(cmd, idx, key, frame);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
